// File: rtl/sev_seg_pkg.sv
// ============================================================================
// sev_seg_pkg : segment patterns, decoder states and CAT encodings
// Revision 1.0
// ============================================================================
`default_nettype none

package sev_seg_pkg;

  // Active-high patterns, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [3:0] CAT_D0 = 4'b0001;
  localparam logic [3:0] CAT_D1 = 4'b0010;
  localparam logic [3:0] CAT_D2 = 4'b0100;
  localparam logic [3:0] CAT_D3 = 4'b1000;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    D1   = 3'd1,
    D2   = 3'd2,
    D3   = 3'd3,
    NEXT = 3'd4
  } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/sev_seg_to_bin.sv
// ============================================================================
// sev_seg_to_bin : combinational seven-segment pattern to hex nibble decode
// Revision 1.0
// ============================================================================
`default_nettype none

module sev_seg_to_bin
  import sev_seg_pkg::*;
(
  input  logic [6:0] SEG,
  input  logic       INV,
  output logic [3:0] BIN,
  output logic       VALID
);

  logic [6:0] pattern;

  always_comb begin
    pattern = INV ? ~SEG : SEG;
    BIN     = 4'h0;
    VALID   = 1'b1;
    case (pattern)
      SEG_0:   BIN = 4'h0;
      SEG_1:   BIN = 4'h1;
      SEG_2:   BIN = 4'h2;
      SEG_3:   BIN = 4'h3;
      SEG_4:   BIN = 4'h4;
      SEG_5:   BIN = 4'h5;
      SEG_6:   BIN = 4'h6;
      SEG_7:   BIN = 4'h7;
      SEG_8:   BIN = 4'h8;
      SEG_9:   BIN = 4'h9;
      SEG_A:   BIN = 4'hA;
      SEG_B:   BIN = 4'hB;
      SEG_C:   BIN = 4'hC;
      SEG_D:   BIN = 4'hD;
      SEG_E:   BIN = 4'hE;
      SEG_F:   BIN = 4'hF;
      default: VALID = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux_sev_seg_decoder.sv
// ============================================================================
// mux_sev_seg_decoder : rebuilds the 16-bit value from a scanned 4-digit bus
// Revision 1.0
// ============================================================================
`default_nettype none

module mux_sev_seg_decoder
  import sev_seg_pkg::*;
#(
  parameter bit INV = 1'b1
) (
  input  logic        MUX_CLK,
  input  logic        RESET,
  input  logic [3:0]  CAT,
  input  logic [6:0]  SEG,
  output logic [15:0] HEX,
  output logic        FRAME_VALID,
  output logic        LOCKED,
  output logic        STABLE,
  output logic        SEQ_ERR,
  output logic        SEG_ERR,
  output logic [7:0]  ERR_CNT
);

  dec_state_t  state, state_nx;
  logic [11:0] shadow, shadow_nx;
  logic        from_next, from_next_nx;
  logic [15:0] hex_nx;
  logic        frame_nx, locked_nx, stable_nx, seq_nx, seg_err_nx;
  logic [7:0]  cnt_nx;
  logic [3:0]  exp_cat;
  logic [3:0]  nibble;
  logic        nibble_ok;
  logic        err;

  sev_seg_to_bin u_dec (
    .SEG   (SEG),
    .INV   (INV),
    .BIN   (nibble),
    .VALID (nibble_ok)
  );

  always_comb begin
    state_nx     = state;
    shadow_nx    = shadow;
    from_next_nx = from_next;
    hex_nx       = HEX;
    frame_nx     = 1'b0;
    locked_nx    = LOCKED;
    stable_nx    = STABLE;
    seq_nx       = 1'b0;
    seg_err_nx   = 1'b0;
    cnt_nx       = ERR_CNT;
    err          = 1'b0;

    case (state)
      D1:      exp_cat = CAT_D1;
      D2:      exp_cat = CAT_D2;
      D3:      exp_cat = CAT_D3;
      default: exp_cat = CAT_D0;
    endcase

    if (state == HUNT) begin
      // Only a digit-0 select can open a frame; anything else is line noise
      if (CAT == CAT_D0) begin
        if (nibble_ok) begin
          shadow_nx    = {shadow[7:0], nibble};
          from_next_nx = 1'b0;
          state_nx     = D1;
        end else begin
          seg_err_nx = 1'b1;
          err        = 1'b1;
        end
      end
    end else if (CAT != exp_cat) begin
      seq_nx = 1'b1;
      err    = 1'b1;
    end else if (!nibble_ok) begin
      seg_err_nx = 1'b1;
      err        = 1'b1;
    end else begin
      shadow_nx = {shadow[7:0], nibble};
      case (state)
        NEXT: begin
          from_next_nx = 1'b1;
          state_nx     = D1;
        end
        D1: state_nx = D2;
        D2: state_nx = D3;
        D3: begin
          hex_nx    = {shadow, nibble};
          frame_nx  = 1'b1;
          locked_nx = 1'b1;
          // STABLE needs two back-to-back frames; one that started in HUNT never qualifies
          stable_nx = from_next && ({shadow, nibble} == HEX);
          state_nx  = NEXT;
        end
        default: state_nx = HUNT;
      endcase
    end

    if (err) begin
      state_nx  = HUNT;
      shadow_nx = 12'h000;
      locked_nx = 1'b0;
      stable_nx = 1'b0;
      if (ERR_CNT != 8'hFF) cnt_nx = ERR_CNT + 8'd1;
    end
  end

  always_ff @(posedge MUX_CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= HUNT;
      shadow      <= 12'h000;
      from_next   <= 1'b0;
      HEX         <= 16'h0000;
      FRAME_VALID <= 1'b0;
      LOCKED      <= 1'b0;
      STABLE      <= 1'b0;
      SEQ_ERR     <= 1'b0;
      SEG_ERR     <= 1'b0;
      ERR_CNT     <= 8'h00;
    end else begin
      state       <= state_nx;
      shadow      <= shadow_nx;
      from_next   <= from_next_nx;
      HEX         <= hex_nx;
      FRAME_VALID <= frame_nx;
      LOCKED      <= locked_nx;
      STABLE      <= stable_nx;
      SEQ_ERR     <= seq_nx;
      SEG_ERR     <= seg_err_nx;
      ERR_CNT     <= cnt_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_sev_seg_decoder.sv
// ============================================================================
// tb_mux_sev_seg_decoder : scoreboard bench for both SEG polarities
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mux_sev_seg_decoder;

  typedef struct packed {
    logic [15:0] hex;
    logic        fv;
    logic        lk;
    logic        st;
    logic        sq;
    logic        sg;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    int          frames;
    logic [15:0] exp_hex;
    logic        exp_locked;
    logic        exp_stable;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cat;
  logic [6:0]  seg_hi;
  logic [6:0]  seg_lo;

  logic [15:0] hex_a, hex_h;
  logic        fv_a, lk_a, st_a, sq_a, sg_a;
  logic        fv_h, lk_h, st_h, sq_h, sg_h;
  logic [7:0]  cnt_a, cnt_h;

  int total = 0;
  int bad   = 0;

  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t sb[$];

  // Reference model state
  int         m_state;
  logic [3:0] m_dig [4];
  bit         m_from_next;
  exp_t       m;

  assign seg_lo = ~seg_hi;

  always #5 clk = ~clk;

  mux_sev_seg_decoder #(.INV(1'b1)) u_dut_al (
    .MUX_CLK(clk), .RESET(rst_n), .CAT(cat), .SEG(seg_lo),
    .HEX(hex_a), .FRAME_VALID(fv_a), .LOCKED(lk_a), .STABLE(st_a),
    .SEQ_ERR(sq_a), .SEG_ERR(sg_a), .ERR_CNT(cnt_a)
  );

  mux_sev_seg_decoder #(.INV(1'b0)) u_dut_ah (
    .MUX_CLK(clk), .RESET(rst_n), .CAT(cat), .SEG(seg_hi),
    .HEX(hex_h), .FRAME_VALID(fv_h), .LOCKED(lk_h), .STABLE(st_h),
    .SEQ_ERR(sq_h), .SEG_ERR(sg_h), .ERR_CNT(cnt_h)
  );

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, want);
    end
  endtask

  task automatic chk_both(input string name, input exp_t e);
    exp_t a, h;
    a = '{hex: hex_a, fv: fv_a, lk: lk_a, st: st_a, sq: sq_a, sg: sg_a, cnt: cnt_a};
    h = '{hex: hex_h, fv: fv_h, lk: lk_h, st: st_h, sq: sq_h, sg: sg_h, cnt: cnt_h};
    chk({name, "/inv1"}, 32'(a), 32'(e));
    chk({name, "/inv0"}, 32'(h), 32'(e));
  endtask

  task automatic model_reset();
    m_state     = 0;
    m_from_next = 0;
    m           = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [6:0] s);
    int         d, idx;
    bit         e;
    logic [3:0] ec;
    logic [15:0] nv;
    d = decode(s);
    e = 0;
    m.fv = 0; m.sq = 0; m.sg = 0;
    if (m_state == 0) begin
      if (c == 4'b0001) begin
        if (d < 0) begin m.sg = 1; e = 1; end
        else begin m_dig[0] = d[3:0]; m_from_next = 0; m_state = 1; end
      end
    end else begin
      ec = (m_state == 4) ? 4'b0001 : 4'(4'b0001 << m_state);
      if (c != ec) begin m.sq = 1; e = 1; end
      else if (d < 0) begin m.sg = 1; e = 1; end
      else begin
        idx = (m_state == 4) ? 0 : m_state;
        if (idx == 0) m_from_next = 1;
        m_dig[idx] = d[3:0];
        if (idx == 3) begin
          nv   = {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
          m.st = m_from_next && (nv == m.hex);
          m.hex = nv;
          m.fv = 1;
          m.lk = 1;
          m_state = 4;
        end else m_state = idx + 1;
      end
    end
    if (e) begin
      m_state = 0;
      m.lk = 0;
      m.st = 0;
      if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [6:0] s, input string tag);
    exp_t e;
    @(negedge clk);
    cat    = c;
    seg_hi = s;
    model_step(c, s);
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_both(tag, e);
  endtask

  task automatic frame(input logic [15:0] v);
    logic [15:0] vv;
    vv = v;
    for (int i = 0; i < 4; i++)
      step(4'(4'b0001 << i), pat_tab[vv[15-4*i -: 4]], "frame");
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{16'hBEEF, 1, 16'hBEEF, 1'b1, 1'b0};
    vecs[1] = '{16'hBEEF, 1, 16'hBEEF, 1'b1, 1'b1};
    vecs[2] = '{16'hBEEF, 1, 16'hBEEF, 1'b1, 1'b1};
    vecs[3] = '{16'h0123, 1, 16'h0123, 1'b1, 1'b0};
    vecs[4] = '{16'h4567, 1, 16'h4567, 1'b1, 1'b0};
    vecs[5] = '{16'h89AB, 1, 16'h89AB, 1'b1, 1'b0};
    vecs[6] = '{16'hCDEF, 1, 16'hCDEF, 1'b1, 1'b0};
    vecs[7] = '{16'h1111, 1, 16'h1111, 1'b1, 1'b0};
    vecs[8] = '{16'h1111, 1, 16'h1111, 1'b1, 1'b1};

    rst_n  = 1'b0;
    cat    = 4'b0000;
    seg_hi = 7'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_both("reset_values", m);
    @(negedge clk);
    rst_n = 1'b1;

    step(4'b0000, 7'h00, "post_reset_idle");

    for (int i = 0; i < 9; i++) begin
      for (int f = 0; f < vecs[i].frames; f++) frame(vecs[i].value);
      chk("vec_hex",    32'(hex_a), 32'(vecs[i].exp_hex));
      chk("vec_locked", 32'(lk_a),  32'(vecs[i].exp_locked));
      chk("vec_stable", 32'(st_a),  32'(vecs[i].exp_stable));
    end

    // Value changes mid-frame: mixed commit, then the new value twice
    step(4'b0001, pat_tab[1], "chg");
    step(4'b0010, pat_tab[1], "chg");
    step(4'b0100, pat_tab[2], "chg");
    step(4'b1000, pat_tab[2], "chg");
    chk("chg_mixed_hex", 32'(hex_a), 32'h1122);
    chk("chg_stable_drop", 32'(st_a), 32'h0);
    frame(16'h2222);
    frame(16'h2222);
    chk("chg_stable_new", 32'(st_a), 32'h1);

    // Sequence error while in D2
    step(4'b0001, pat_tab[3], "seq");
    step(4'b0010, pat_tab[3], "seq");
    step(4'b1000, pat_tab[3], "seq");
    chk("seq_pulse", 32'(sq_a), 32'h1);
    chk("seq_locked", 32'(lk_a), 32'h0);
    chk("seq_cnt", 32'(cnt_a), 32'h1);
    chk("seq_hex_kept", 32'(hex_a), 32'h2222);
    frame(16'h5A5A);
    chk("seq_relock", 32'(lk_a), 32'h1);

    // Segment error in D1, then both wrong at once
    step(4'b0001, pat_tab[7], "segerr");
    step(4'b0010, 7'h00, "segerr");
    chk("seg_pulse", 32'(sg_a), 32'h1);
    chk("seg_cnt", 32'(cnt_a), 32'h2);
    frame(16'h5A5A);
    step(4'b0001, pat_tab[7], "both");
    step(4'b1000, 7'h00, "both");
    chk("both_seq", 32'(sq_a), 32'h1);
    chk("both_no_seg", 32'(sg_a), 32'h0);
    step(4'b0001, pat_tab[0], "multihot");
    step(4'b0011, pat_tab[0], "multihot");
    chk("multihot_cnt", 32'(cnt_a), 32'h4);

    // Asynchronous reset while in D3
    frame(16'hBEEF);
    step(4'b0001, pat_tab[4], "rst_mid");
    step(4'b0010, pat_tab[4], "rst_mid");
    step(4'b0100, pat_tab[4], "rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_both("async_reset", m);
    @(negedge clk);
    rst_n = 1'b1;
    frame(16'hBEEF);
    chk("post_reset_hex", 32'(hex_a), 32'hBEEF);

    // Counter saturation
    repeat (300) step(4'b0001, 7'h00, "sat");
    chk("sat_cnt", 32'(cnt_a), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
